// File: rtl/alu_fixed_point.sv
// rtl/alu_fixed_point.sv - registered signed fixed-point add/sub/mul/div ALU
// Result is computed combinationally from a, b, selector and captured with a zero flag each rising edge.
module alu_fixed_point #(
  parameter int N    = 32,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   selector,
  output logic         zero,
  output logic [N-1:0] out
);

  localparam logic [N-1:0]   POS_SAT = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   NEG_SAT = {1'b1, {(N-1){1'b0}}};
  localparam logic [2*N-1:0] ONE_2N  = {{(2*N-1){1'b0}}, 1'b1};

  logic signed [2*N-1:0] a_ext;
  logic signed [2*N-1:0] b_ext;
  logic signed [2*N-1:0] dividend;
  logic signed [2*N-1:0] divisor;
  logic [N-1:0]          mul_res;
  logic [N-1:0]          div_res;
  logic [N-1:0]          result;

  always_comb begin
    a_ext    = {{N{a[N-1]}}, a};
    b_ext    = {{N{b[N-1]}}, b};
    // FRAC < N keeps the scaled dividend inside 2N bits, so the divide never overflows
    dividend = a_ext <<< FRAC;
    // divisor forced to 1 on b == 0 so the unused quotient never goes undefined
    divisor  = (b == '0) ? $signed(ONE_2N) : b_ext;
    mul_res  = N'((a_ext * b_ext) >>> FRAC);
    div_res  = N'(dividend / divisor);

    result = '0;
    case (selector)
      2'b00: result = a + b;
      2'b01: result = a - b;
      2'b10: result = mul_res;
      2'b11: begin
        if (b == '0) result = a[N-1] ? NEG_SAT : POS_SAT;
        else         result = div_res;
      end
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      zero <= 1'b1;
    end else begin
      out  <= result;
      zero <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu_fixed_point.sv
// tb/tb_alu_fixed_point.sv - randomized self-checking bench for alu_fixed_point
// Expected results come from a 64-bit integer arithmetic model of the Q20.12 operations.
module tb_alu_fixed_point;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  selector;
  logic        zero;
  logic [31:0] out;

  int n_checks;
  int n_fail;

  alu_fixed_point #(.N(32), .FRAC(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .selector (selector),
    .zero     (zero),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] s);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (s)
      2'b00: r = sa + sb;
      2'b01: r = sa - sb;
      2'b10: r = (sa * sb) >>> 12;
      default: begin
        if (sb == 0) r = (sa >= 0) ? 64'sd2147483647 : -64'sd2147483648;
        else         r = (sa * 4096) / sb;
      end
    endcase
    return r[31:0];
  endfunction

  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic [1:0] s);
    logic [31:0] exp_out;
    @(negedge clk);
    a = av;
    b = bv;
    selector = s;
    exp_out = model(av, bv, s);
    @(posedge clk);
    #1;
    check({tag, ".out"}, out, exp_out);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_out == 32'd0});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rs;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    a = '0;
    b = '0;
    selector = 2'b00;

    // reset asserted between edges must act at once and hold across edges
    #3 rst = 1'b1;
    #1;
    check("reset.out", out, 32'd0);
    check("reset.zero", {31'd0, zero}, 32'd1);
    a = 32'd847872; b = 32'd2048; selector = 2'b00;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold.out", out, 32'd0);
      check("reset_hold.zero", {31'd0, zero}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // directed cases from the test plan, with literal expectations
    do_op("mul", 32'd847872, 32'd2048, 2'b10);
    check("mul.lit", out, 32'd423936);
    do_op("chain_sub", out, 32'd2048, 2'b01);
    check("chain_sub.lit", out, 32'd421888);
    do_op("add_zero", 32'd4096, 32'hFFFFF000, 2'b00);
    check("add_zero.lit", {31'd0, zero}, 32'd1);
    do_op("add_wrap", 32'h7FFFFFFF, 32'd1, 2'b00);
    check("add_wrap.lit", out, 32'h80000000);
    do_op("div", 32'd847872, 32'd2048, 2'b11);
    check("div.lit", out, 32'd1695744);
    do_op("div0_pos", 32'd847872, 32'd0, 2'b11);
    check("div0_pos.lit", out, 32'h7FFFFFFF);
    do_op("div0_neg", 32'hFFFFF000, 32'd0, 2'b11);
    check("div0_neg.lit", out, 32'h80000000);
    do_op("div0_zero_a", 32'd0, 32'd0, 2'b11);
    do_op("div_neg", 32'hFFFFE000, 32'd12288, 2'b11);
    do_op("mul_neg", 32'hFFFFF001, 32'd2048, 2'b10);
    do_op("sub_wrap", 32'h80000000, 32'd1, 2'b01);

    // asynchronous reset pulse mid-stream, then fresh compute from current inputs
    do_op("pre_rst_mul", 32'd847872, 32'd8192, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("midrst.out", out, 32'd0);
    check("midrst.zero", {31'd0, zero}, 32'd1);
    a = 32'd40960; b = 32'd4096; selector = 2'b01;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.out", out, 32'd36864);
    check("post_rst.zero", {31'd0, zero}, 32'd0);

    // randomized ops, sometimes chaining out back into a and sometimes dividing by zero
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = out;
        1: rb = '0;
        2: rb = 32'($signed(16'($urandom)));
        3: ra = 32'($signed(20'($urandom)));
        4: rb = ra;
        default: ;
      endcase
      if (rs == 2'b00 && $urandom_range(0, 9) == 0) rb = -ra;
      do_op("rand", ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_fixed_point.md
Name: alu_fixed_point

Overview:
- Registered signed fixed-point ALU for the PF (fixed-point) arithmetic path of the core.
- Performs add, subtract, multiply or divide on two N-bit two's-complement operands, with FRAC fractional bits.
- Captures the result and a zero flag in output registers on each rising clock edge.
- Used wherever the datapath needs fractional arithmetic, e.g. Q20.12 values such as 207.0 = 847872.

Parameters:
- N, 32, operand and result width in bits (the codebase instantiates it positionally as #(32)).
- FRAC, 12, number of fractional bits. Must satisfy 0 <= FRAC < N.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset, asynchronous and active-high.
- a  input  N  operand A, signed fixed point.
- b  input  N  operand B, signed fixed point.
- selector  input  2  operation select.
- zero  output  1  registered flag; 1 when out == 0.
- out  output  N  registered result, signed fixed point.

Behaviour:
- Reset:
  - rst high clears out to 0 and sets zero to 1 immediately, without waiting for clk.
  - While rst is high, the outputs hold those values and clock edges are ignored.
  - Deasserting rst mid-operation discards any in-flight operation; no partial result is ever shown.
- Latency:
  - a, b and selector are sampled at a rising edge of clk.
  - out and zero reflect that operation right after the same edge (one-cycle latency).
  - They hold until the next edge, so a new operation can be issued every cycle.
  - The result computation itself is combinational; there is no handshake.
- Operation encoding (selector):
  - 2'b00 add: out = a + b, wrapped to N bits.
  - 2'b01 sub: out = a - b, wrapped to N bits.
  - 2'b10 mul: form the full 2N-bit signed product a*b, arithmetic-shift it right by FRAC (truncation toward minus infinity), keep the low N bits (wrap on overflow).
  - 2'b11 div: quotient = (sign-extended a << FRAC) / b as a signed integer divide truncating toward zero; keep the low N bits.
- Division by zero (b == 0):
  - out = 2^(N-1)-1 (0x7FFF_FFFF for N=32) when a >= 0.
  - out = -2^(N-1) (0x8000_0000) when a < 0.
- No carry or overflow flags. Overflow in add/sub/mul/div wraps silently.
- zero is derived from the value being registered into out, so the two are always consistent.
- The same registered out may be fed back to a in the following cycle; that chaining must work.

Test Plan:
- Reset: assert rst between clock edges. Require out=0 and zero=1 immediately; both hold through edges while rst=1.
- Mul: a=847872 (207.0), b=2048 (0.5), selector=2'b10, one edge. Require out=423936 (103.5), zero=0.
- Chained sub: next cycle a=out (423936), b=2048, selector=2'b01. Require out=421888 (103.0).
- Add to zero: a=4096 (1.0), b=0xFFFFF000 (-1.0), selector=2'b00. Require out=0, zero=1. Then a=0x7FFFFFFF, b=1 must wrap to out=0x80000000.
- Div: a=847872, b=2048, selector=2'b11. Require out=1695744 (414.0). With b=0: a=847872 gives 0x7FFFFFFF, a=-4096 gives 0x80000000.
- Async reset mid-stream: issue mul, then pulse rst between edges. Require out=0 and zero=1 at once; the first edge after release computes fresh from the current inputs.
